// File: rtl/vblank_dma_ctrl.sv
// Bus-mastering block copy for the Aznable map: CPU programs SRC/DST/LEN, START takes the Z80 bus
// via BUSRQ/BUSAK and copies one byte every three clocks, optionally only while vblank is high.
//   state  | meaning
//   IDLE   | waiting for START
//   ARM    | started, waiting for vblank when VBL_ONLY is set
//   REQ    | busrq asserted, waiting for busak
//   RD     | source address on the bus
//   LAT    | source byte returns, captured into dma_dout
//   WR     | byte written to destination, counters stepped
//   REL    | bus released, waiting for busak to drop
//   DONE   | one-cycle completion pulse
`timescale 1ns/1ps
module vblank_dma_ctrl #(
  parameter logic [7:0] REG_PAGE = 8'h8B,
  parameter int         LEN_W    = 8
) (
  input  logic        clk_24,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr_n,
  input  logic        cpu_mreq_n,
  output logic        reg_cs,
  output logic [7:0]  reg_data_out,
  input  logic        vblank,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_wr,
  output logic        done_pulse
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_REQ, S_RD, S_LAT, S_WR, S_REL, S_DONE
  } state_t;

  localparam logic [LEN_W:0] LEN_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] LEN_FULL = LEN_ONE << LEN_W;

  state_t         r_state;
  logic [15:0]    r_src;
  logic [15:0]    r_dst;
  logic [LEN_W:0] r_len;
  logic           r_vbl_only;
  logic           r_done;
  logic           r_err;
  logic           r_wr_prev;
  logic           r_st_prev;
  logic           r_busrq_n;
  logic           r_dma_active;
  logic [15:0]    r_dma_addr;
  logic [7:0]     r_dma_dout;
  logic           r_dma_wr;
  logic           r_done_pulse;

  logic [2:0] w_off;
  logic       w_reg_cs;
  logic       w_wr_cyc;
  logic       w_wr_acc;
  logic       w_st_rd;
  logic       w_start;
  logic       w_busy;
  logic       w_unused_addr;

  assign w_off         = cpu_addr[2:0];
  assign w_reg_cs      = (cpu_addr[15:8] == REG_PAGE) && !cpu_mreq_n;
  assign w_wr_cyc      = w_reg_cs && !cpu_wr_n;
  assign w_wr_acc      = w_wr_cyc && !r_wr_prev;
  assign w_st_rd       = w_reg_cs && cpu_wr_n && (w_off == 3'd5);
  assign w_start       = w_wr_acc && (w_off == 3'd5) && cpu_dout[0];
  assign w_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_unused_addr = &{1'b0, cpu_addr[7:3]};

  assign reg_cs      = w_reg_cs;
  assign cpu_busrq_n = r_busrq_n;
  assign dma_active  = r_dma_active;
  assign dma_addr    = r_dma_addr;
  assign dma_dout    = r_dma_dout;
  assign dma_wr      = r_dma_wr;
  assign done_pulse  = r_done_pulse;

  always_comb begin
    reg_data_out = 8'h00;
    case (w_off)
      3'd0:    reg_data_out = r_src[7:0];
      3'd1:    reg_data_out = r_src[15:8];
      3'd2:    reg_data_out = r_dst[7:0];
      3'd3:    reg_data_out = r_dst[15:8];
      3'd4:    reg_data_out = 8'(r_len[LEN_W-1:0]);
      3'd5:    reg_data_out = {5'b0, r_err, r_done, w_busy};
      default: reg_data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_vbl_only   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_wr_prev    <= 1'b0;
      r_st_prev    <= 1'b0;
      r_busrq_n    <= 1'b1;
      r_dma_active <= 1'b0;
      r_dma_addr   <= '0;
      r_dma_dout   <= '0;
      r_dma_wr     <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_wr_prev    <= w_wr_cyc;
      r_st_prev    <= w_st_rd;
      r_dma_wr     <= 1'b0;
      r_done_pulse <= 1'b0;

      if (w_st_rd && !r_st_prev) r_done <= 1'b0;

      if (w_wr_acc && !w_busy) begin
        case (w_off)
          3'd0:    r_src[7:0]  <= cpu_dout;
          3'd1:    r_src[15:8] <= cpu_dout;
          3'd2:    r_dst[7:0]  <= cpu_dout;
          3'd3:    r_dst[15:8] <= cpu_dout;
          3'd4:    r_len       <= {1'b0, cpu_dout[LEN_W-1:0]};
          3'd5:    r_vbl_only  <= cpu_dout[1];
          default: ;
        endcase
      end

      if (w_start && w_busy) r_err <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            // a zero length counter means a full 2**LEN_W block
            if (r_len == '0) r_len <= LEN_FULL;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (!r_vbl_only || vblank) begin
            r_busrq_n <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (!cpu_busak_n) begin
            r_dma_active <= 1'b1;
            r_dma_addr   <= r_src;
            r_state      <= S_RD;
          end
        end
        S_RD: r_state <= S_LAT;
        S_LAT: begin
          r_dma_dout <= dma_din;
          r_dma_addr <= r_dst;
          r_dma_wr   <= 1'b1;
          r_state    <= S_WR;
        end
        S_WR: begin
          r_src <= r_src + 16'd1;
          r_dst <= r_dst + 16'd1;
          r_len <= r_len - LEN_ONE;
          if ((r_len == LEN_ONE) || (r_vbl_only && !vblank)) begin
            r_busrq_n    <= 1'b1;
            r_dma_active <= 1'b0;
            r_state      <= S_REL;
          end else begin
            r_dma_addr <= r_src + 16'd1;
            r_state    <= S_RD;
          end
        end
        S_REL: begin
          if (cpu_busak_n) begin
            if (r_len == '0) begin
              r_done       <= 1'b1;
              r_done_pulse <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_dma_ctrl.sv
// Bench for vblank_dma_ctrl: register table vectors, then copy sequences checked against a
// write scoreboard fed from a pattern-filled memory model with a two-cycle busak responder.
`timescale 1ns/1ps
module tb_vblank_dma_ctrl;

  logic        clk_24 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_mreq_n = 1'b1;
  logic        reg_cs;
  logic [7:0]  reg_data_out;
  logic        vblank = 1'b0;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din = '0;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        done_pulse;

  vblank_dma_ctrl dut (
    .clk_24(clk_24), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr_n(cpu_wr_n), .cpu_mreq_n(cpu_mreq_n), .reg_cs(reg_cs), .reg_data_out(reg_data_out),
    .vblank(vblank), .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n), .dma_active(dma_active),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_dout(dma_dout), .dma_wr(dma_wr),
    .done_pulse(done_pulse)
  );

  always #21 clk_24 = ~clk_24;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [15:0] a; logic mreq_n; logic wr; logic [7:0] wd; logic cs; logic [7:0] rd;
  } vec_t;

  logic [7:0] mem [0:65535];
  logic [1:0] r_ak = 2'b11;
  wr_t        exp_q[$];
  wr_t        mon_e;
  int n_cmp = 0, n_err = 0, n_wr = 0, n_done = 0, n_act = 0;

  assign cpu_busak_n = r_ak[1];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk_24) begin
    r_ak    <= {r_ak[0], cpu_busrq_n};
    dma_din <= mem[dma_addr];
    if (dma_wr) mem[dma_addr] <= dma_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_24) begin
    if (dma_active) n_act++;
    if (done_pulse) n_done++;
    if (dma_wr) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", dma_addr, dma_dout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {16'h0, dma_addr}, {16'h0, mon_e.a});
        chk("wr_data", {24'h0, dma_dout}, {24'h0, mon_e.d});
      end
    end
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic mreq_n, input int hold);
    @(negedge clk_24);
    cpu_addr = a; cpu_dout = d; cpu_mreq_n = mreq_n; cpu_wr_n = 1'b0;
    repeat (hold) @(negedge clk_24);
    cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
  endtask

  task automatic wreg(input logic [2:0] off, input logic [7:0] d);
    cpu_wr({13'h8B << 5, off}, d, 1'b0, 1);
  endtask

  task automatic rreg(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk_24);
    cpu_addr = {13'h8B << 5, off}; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b1;
    #1 d = reg_data_out;
    @(negedge clk_24);
    cpu_mreq_n = 1'b1;
  endtask

  task automatic chk_reg(input string nm, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] v;
    rreg(off, v);
    chk(nm, {24'h0, v}, {24'h0, exp});
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [7:0] len);
    wreg(3'd0, s[7:0]); wreg(3'd1, s[15:8]);
    wreg(3'd2, d[7:0]); wreg(3'd3, d[15:8]);
    wreg(3'd4, len);
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = d + 16'(i);
      e.d = pat(s + 16'(i));
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_24);
      if (done_pulse) seen = 1'b1;
    end
    chk(nm, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[12];
    int   d0, w0, c;
    logic seen;

    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));

    tv[0]  = '{16'h8B00, 1'b0, 1'b1, 8'h34, 1'b1, 8'h34};
    tv[1]  = '{16'h8B01, 1'b0, 1'b1, 8'h12, 1'b1, 8'h12};
    tv[2]  = '{16'h8B02, 1'b0, 1'b1, 8'h78, 1'b1, 8'h78};
    tv[3]  = '{16'h8B03, 1'b0, 1'b1, 8'h56, 1'b1, 8'h56};
    tv[4]  = '{16'h8B04, 1'b0, 1'b1, 8'h9A, 1'b1, 8'h9A};
    tv[5]  = '{16'h8B05, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tv[6]  = '{16'h8B06, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00};
    tv[7]  = '{16'h8B07, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tv[8]  = '{16'h8C00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h34};
    tv[9]  = '{16'h8B01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h12};
    tv[10] = '{16'h8B00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h34};
    tv[11] = '{16'h7B04, 1'b0, 1'b1, 8'h11, 1'b0, 8'h9A};

    // reset values, sampled while reset is held
    repeat (3) @(negedge clk_24);
    chk("rst_busrq_n", {31'h0, cpu_busrq_n}, 32'h1);
    chk("rst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("rst_dma_wr", {31'h0, dma_wr}, 32'h0);
    chk("rst_dma_addr", {16'h0, dma_addr}, 32'h0);
    chk("rst_dma_dout", {24'h0, dma_dout}, 32'h0);
    chk("rst_done_pulse", {31'h0, done_pulse}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 8'h00);

    for (int i = 0; i < 12; i++) begin
      if (tv[i].wr) cpu_wr(tv[i].a, tv[i].wd, tv[i].mreq_n, 1);
      @(negedge clk_24);
      cpu_addr = tv[i].a; cpu_mreq_n = tv[i].mreq_n; cpu_wr_n = 1'b1;
      #1;
      chk($sformatf("tv%0d_cs", i), {31'h0, reg_cs}, {31'h0, tv[i].cs});
      chk($sformatf("tv%0d_rd", i), {24'h0, reg_data_out}, {24'h0, tv[i].rd});
      @(negedge clk_24);
      cpu_mreq_n = 1'b1;
    end

    // 128-byte copy C000 -> B000
    program_regs(16'hC000, 16'hB000, 8'h80);
    push_copy(16'hC000, 16'hB000, 128);
    n_act = 0; d0 = n_done;
    wreg(3'd5, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_24);
      if (!cpu_busrq_n) seen = 1'b1;
    end
    chk("t1_busrq", {31'h0, seen}, 32'h1);
    wait_done("t1_done", 1000);
    repeat (5) @(negedge clk_24);
    chk("t1_active_cycles", n_act, 384);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk_reg("t1_status", 3'd5, 8'h02);
    chk_reg("t1_status2", 3'd5, 8'h00);
    chk_reg("t1_src_lo", 3'd0, 8'h80);
    chk_reg("t1_src_hi", 3'd1, 8'hC0);
    chk_reg("t1_len", 3'd4, 8'h00);

    // LEN=0 is 256 bytes, source wraps through 0000
    program_regs(16'hFFF0, 16'h9800, 8'h00);
    push_copy(16'hFFF0, 16'h9800, 256);
    wreg(3'd5, 8'h01);
    wait_done("t2_done", 2000);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk_reg("t2_src_lo", 3'd0, 8'hF0);
    chk_reg("t2_src_hi", 3'd1, 8'h00);
    chk_reg("t2_dst_hi", 3'd3, 8'h99);

    // vblank-gated copy interrupted after 10 bytes
    vblank = 1'b0;
    program_regs(16'h2000, 16'hA000, 8'h20);
    push_copy(16'h2000, 16'hA000, 32);
    w0 = n_wr;
    wreg(3'd5, 8'h03);
    repeat (20) @(negedge clk_24);
    chk("t3_no_busrq", {31'h0, cpu_busrq_n}, 32'h1);
    chk_reg("t3_status_arm", 3'd5, 8'h01);
    vblank = 1'b1;
    c = 0;
    for (int i = 0; i < 400 && c < 10; i++) begin
      @(negedge clk_24);
      if (dma_wr) c++;
    end
    vblank = 1'b0;
    chk("t3_ten_seen", c, 10);
    repeat (30) @(negedge clk_24);
    chk("t3_ten_written", n_wr - w0, 10);
    chk("t3_released", {31'h0, cpu_busrq_n}, 32'h1);
    chk("t3_inactive", {31'h0, dma_active}, 32'h0);
    chk_reg("t3_status_paused", 3'd5, 8'h01);
    chk_reg("t3_len_left", 3'd4, 8'h16);
    chk_reg("t3_src_lo", 3'd0, 8'h0A);
    vblank = 1'b1;
    wait_done("t3_done", 1000);
    chk("t3_total", n_wr - w0, 32);
    chk("t3_queue_empty", exp_q.size(), 0);

    // START while busy sets err, transfer unaffected
    vblank = 1'b0;
    program_regs(16'h5000, 16'h6000, 8'h06);
    push_copy(16'h5000, 16'h6000, 6);
    wreg(3'd5, 8'h03);
    wreg(3'd5, 8'h01);
    repeat (10) @(negedge clk_24);
    chk("t4_still_gated", {31'h0, cpu_busrq_n}, 32'h1);
    chk_reg("t4_status_err", 3'd5, 8'h05);
    vblank = 1'b1;
    wait_done("t4_done", 500);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk_reg("t4_status_done", 3'd5, 8'h06);
    chk_reg("t4_status_rd2", 3'd5, 8'h04);
    program_regs(16'h5100, 16'h6100, 8'h02);
    push_copy(16'h5100, 16'h6100, 2);
    wreg(3'd5, 8'h01);
    chk_reg("t4_err_cleared", 3'd5, 8'h01);
    wait_done("t4b_done", 500);
    chk_reg("t4b_status", 3'd5, 8'h02);

    // a write strobe held for 4 cycles starts one transfer only
    program_regs(16'h7000, 16'h7800, 8'h04);
    push_copy(16'h7000, 16'h7800, 4);
    w0 = n_wr; d0 = n_done;
    cpu_wr(16'h8B05, 8'h01, 1'b0, 4);
    wait_done("t5_done", 500);
    repeat (40) @(negedge clk_24);
    chk("t5_one_done", n_done - d0, 1);
    chk("t5_writes", n_wr - w0, 4);
    chk_reg("t5_status", 3'd5, 8'h02);

    // reset asserted during WR
    program_regs(16'h3000, 16'h4000, 8'h08);
    push_copy(16'h3000, 16'h4000, 8);
    wreg(3'd5, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_24);
      if (dma_wr) seen = 1'b1;
    end
    chk("t6_in_wr", {31'h0, seen}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_busrq_n", {31'h0, cpu_busrq_n}, 32'h1);
    chk("t6_dma_wr", {31'h0, dma_wr}, 32'h0);
    chk("t6_dma_active", {31'h0, dma_active}, 32'h0);
    chk("t6_dma_addr", {16'h0, dma_addr}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk_24);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_24);
    chk_reg("t6_status", 3'd5, 8'h00);
    chk_reg("t6_src_lo", 3'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
